// File: rtl/jk_pkg.sv
// Shared types for the JK register bank: operating-mode encoding.
package jk_pkg;
    typedef enum logic [1:0] {
        JK     = 2'd0,
        D      = 2'd1,
        CNT_UP = 2'd2,
        CNT_DN = 2'd3
    } jk_mode_t;
endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with async active-low reset to a per-cell value and a
// synchronous enable; also exposes its next-state so the bank can detect change.
module jk_cell (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rst_val,
    input  logic i_en,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_nxt
);
    logic r_q;
    logic w_jk_nxt;

    always_comb begin
        case ({i_j, i_k})
            2'b01:   w_jk_nxt = 1'b0;
            2'b10:   w_jk_nxt = 1'b1;
            2'b11:   w_jk_nxt = ~r_q;
            default: w_jk_nxt = r_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_q <= i_rst_val;
        else if (i_en) r_q <= w_jk_nxt;
    end

    assign o_nxt = i_en ? w_jk_nxt : r_q;
    assign o_q   = r_q;
endmodule

// File: rtl/jk_reg_bank.sv
// Multi-mode bank of JK flip-flops: plain JK, D register, or wrapping up/down
// counter built from toggling cells. Flags terminal count and value change.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] outbar,
    output logic             tc,
    output logic             changed
);
    jk_mode_t         w_mode;
    logic [WIDTH:0]   w_all1;
    logic [WIDTH:0]   w_all0;
    logic [WIDTH-1:0] w_ej;
    logic [WIDTH-1:0] w_ek;
    logic [WIDTH-1:0] w_nxt;
    logic             r_changed;

    assign w_mode = jk_mode_t'(mode);

    // Prefix chains: bit i toggles in a counter when all lower bits are 1 (up) / 0 (down).
    assign w_all1[0] = 1'b1;
    assign w_all0[0] = 1'b1;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        assign w_all1[gi+1] = w_all1[gi] & out[gi];
        assign w_all0[gi+1] = w_all0[gi] & ~out[gi];

        jk_cell u_cell (
            .i_clk     (clk),
            .i_rst_n   (reset),
            .i_rst_val (RESET_VALUE[gi]),
            .i_en      (en),
            .i_j       (w_ej[gi]),
            .i_k       (w_ek[gi]),
            .o_q       (out[gi]),
            .o_nxt     (w_nxt[gi])
        );
    end

    always_comb begin
        case (w_mode)
            D: begin
                w_ej = j;
                w_ek = ~j;
            end
            CNT_UP: begin
                w_ej = w_all1[WIDTH-1:0];
                w_ek = w_all1[WIDTH-1:0];
            end
            CNT_DN: begin
                w_ej = w_all0[WIDTH-1:0];
                w_ek = w_all0[WIDTH-1:0];
            end
            default: begin
                w_ej = j;
                w_ek = k;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_changed <= 1'b0;
        else        r_changed <= (w_nxt != out);
    end

    assign tc      = en && (((w_mode == CNT_UP) && w_all1[WIDTH]) ||
                            ((w_mode == CNT_DN) && w_all0[WIDTH]));
    assign outbar  = ~out;
    assign changed = r_changed;
endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank at WIDTH 8, 1 and 16 with a scoreboard queue.
`timescale 1ns/1ps
module tb_jk_reg_bank;
    import jk_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] out;
        logic        chg;
        logic        tc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b0, en8 = 1'b0, tc8, ch8;
    logic [1:0]  mode8 = 2'd0;
    logic [7:0]  j8 = '0, k8 = '0, out8, ob8;

    logic        rst1 = 1'b0, en1 = 1'b0, tc1, ch1;
    logic [1:0]  mode1 = 2'd0;
    logic [0:0]  j1 = '0, k1 = '0, out1, ob1;

    logic        rst16 = 1'b0, en16 = 1'b0, tc16, ch16;
    logic [1:0]  mode16 = 2'd0;
    logic [15:0] j16 = '0, k16 = '0, out16, ob16;

    jk_reg_bank #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .en(en8), .mode(mode8), .j(j8), .k(k8),
        .out(out8), .outbar(ob8), .tc(tc8), .changed(ch8)
    );
    jk_reg_bank #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(rst1), .en(en1), .mode(mode1), .j(j1), .k(k1),
        .out(out1), .outbar(ob1), .tc(tc1), .changed(ch1)
    );
    jk_reg_bank #(.WIDTH(16), .RESET_VALUE(16'h8000)) dut16 (
        .clk(clk), .reset(rst16), .en(en16), .mode(mode16), .j(j16), .k(k16),
        .out(out16), .outbar(ob16), .tc(tc16), .changed(ch16)
    );

    task automatic cmp(input string tag, input string what, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: got %h expected %h", tag, what, obs, exp);
        end
    endtask

    // Pop one expectation and compare it against the selected instance.
    task automatic check_out(input int w);
        exp_t        it;
        logic [15:0] o, ob, msk;
        logic        c, t;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard: empty queue got 0 expected 1");
            return;
        end
        it = sb.pop_front();
        case (w)
            1:  begin o = {15'd0, out1}; ob = {15'd0, ob1}; c = ch1;  t = tc1;  msk = 16'h0001; end
            16: begin o = out16;         ob = ob16;         c = ch16; t = tc16; msk = 16'hFFFF; end
            default: begin o = {8'd0, out8}; ob = {8'd0, ob8}; c = ch8; t = tc8; msk = 16'h00FF; end
        endcase
        cmp(it.tag, "out",     o,  it.out & msk);
        cmp(it.tag, "outbar",  ob, ~it.out & msk);
        cmp(it.tag, "changed", {15'd0, c}, {15'd0, it.chg});
        cmp(it.tag, "tc",      {15'd0, t}, {15'd0, it.tc});
    endtask

    task automatic expect_now(input int w, input logic [15:0] eo, input logic ec, input logic et, input string tag);
        sb.push_back('{tag, eo, ec, et});
        check_out(w);
    endtask

    task automatic step(input int w, input logic [1:0] m, input logic e,
                        input logic [15:0] jj, input logic [15:0] kk,
                        input logic [15:0] eo, input logic ec, input logic et, input string tag);
        @(negedge clk);
        case (w)
            1:  begin mode1  = m; en1  = e; j1  = jj[0];    k1  = kk[0];    end
            16: begin mode16 = m; en16 = e; j16 = jj;       k16 = kk;       end
            default: begin mode8 = m; en8 = e; j8 = jj[7:0]; k8 = kk[7:0]; end
        endcase
        sb.push_back('{tag, eo, ec, et});
        @(posedge clk);
        #1;
        check_out(w);
    endtask

    function automatic logic [7:0] model8(input logic [7:0] q, input logic [1:0] m, input logic e,
                                          input logic [7:0] jj, input logic [7:0] kk);
        if (!e) return q;
        case (m)
            2'd0:    return (q & ~kk) | (~q & jj);
            2'd1:    return jj;
            2'd2:    return q + 8'd1;
            default: return q - 8'd1;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m8, nx, rj, rk;
        logic [1:0] rm;
        logic       re, rt;

        // Reset held with the clock running and every JK bit asking to toggle.
        mode8 = JK; en8 = 1'b1; j8 = 8'hFF; k8 = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        expect_now(8,  16'h0000, 1'b0, 1'b0, "rst8");
        expect_now(1,  16'h0000, 1'b0, 1'b0, "rst1");
        expect_now(16, 16'h8000, 1'b0, 1'b0, "rst16");

        #1 rst8 = 1'b1;
        step(8, JK, 1'b1, 16'hFF, 16'hFF, 16'h00FF, 1'b1, 1'b0, "jk_first");

        // JK truth table from 0xA5.
        step(8, D,  1'b1, 16'hA5, 16'h00, 16'h00A5, 1'b1, 1'b0, "load_a5");
        step(8, JK, 1'b1, 16'h0F, 16'hF0, 16'h000F, 1'b1, 1'b0, "jk_setclr");
        step(8, JK, 1'b1, 16'hFF, 16'hFF, 16'h00F0, 1'b1, 1'b0, "jk_toggle");
        step(8, JK, 1'b1, 16'h00, 16'h00, 16'h00F0, 1'b0, 1'b0, "jk_hold");

        // Counter wrap both directions; j/k are garbage to show they are ignored.
        step(8, D,      1'b1, 16'hFE, 16'h00, 16'h00FE, 1'b1, 1'b0, "load_fe");
        step(8, CNT_UP, 1'b1, 16'h5A, 16'hC3, 16'h00FF, 1'b1, 1'b1, "up_ff");
        step(8, CNT_UP, 1'b1, 16'h33, 16'h81, 16'h0000, 1'b1, 1'b0, "up_wrap");
        mode8 = CNT_DN;
        #1;
        expect_now(8, 16'h0000, 1'b1, 1'b1, "dn_tc_at0");
        step(8, CNT_DN, 1'b1, 16'h77, 16'h11, 16'h00FF, 1'b1, 1'b0, "dn_wrap");

        // Enable low holds everything; D rewrite of the same value is no change.
        step(8, D,      1'b1, 16'h10, 16'h00, 16'h0010, 1'b1, 1'b0, "load_10");
        for (int i = 0; i < 3; i++)
            step(8, CNT_UP, 1'b0, 16'hFF, 16'hFF, 16'h0010, 1'b0, 1'b0, "en_off");
        step(8, D,      1'b1, 16'h10, 16'hFF, 16'h0010, 1'b0, 1'b0, "d_same");

        // Async reset pulse between edges during a count.
        step(8, D,      1'b1, 16'h37, 16'h00, 16'h0037, 1'b1, 1'b0, "load_37");
        step(8, CNT_UP, 1'b1, 16'h00, 16'h00, 16'h0038, 1'b1, 1'b0, "up_38");
        #1 rst8 = 1'b0;
        #1 expect_now(8, 16'h0000, 1'b0, 1'b0, "async_rst");
        #1 rst8 = 1'b1;
        step(8, CNT_UP, 1'b1, 16'h00, 16'h00, 16'h0001, 1'b1, 1'b0, "resume_01");
        step(8, CNT_UP, 1'b1, 16'h00, 16'h00, 16'h0002, 1'b1, 1'b0, "resume_02");

        // Mixed random traffic checked against a behavioural model.
        m8 = 8'h02;
        for (int i = 0; i < 24; i++) begin
            rm = 2'($urandom_range(0, 3));
            re = ($urandom_range(0, 3) != 0);
            rj = 8'($urandom);
            rk = 8'($urandom);
            nx = model8(m8, rm, re, rj, rk);
            rt = re && (((rm == 2'd2) && (nx == 8'hFF)) || ((rm == 2'd3) && (nx == 8'h00)));
            step(8, rm, re, {8'd0, rj}, {8'd0, rk}, {8'd0, nx}, (nx != m8), rt, "rand");
            m8 = nx;
        end

        // WIDTH=1: both counter directions toggle.
        @(posedge clk);
        #2 rst1 = 1'b1;
        step(1, CNT_UP, 1'b1, 16'h0, 16'h0, 16'h1, 1'b1, 1'b1, "w1_up1");
        step(1, CNT_UP, 1'b1, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, "w1_up0");
        step(1, CNT_DN, 1'b1, 16'h0, 16'h0, 16'h1, 1'b1, 1'b0, "w1_dn1");
        step(1, CNT_DN, 1'b1, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, "w1_dn0");
        step(1, JK,     1'b1, 16'h1, 16'h1, 16'h1, 1'b1, 1'b0, "w1_jk");

        // WIDTH=16 with non-zero reset value.
        @(posedge clk);
        #2 rst16 = 1'b1;
        step(16, CNT_DN, 1'b1, 16'h1234, 16'h0, 16'h7FFF, 1'b1, 1'b0, "w16_dn1");
        step(16, CNT_DN, 1'b1, 16'h0,    16'h0, 16'h7FFE, 1'b1, 1'b0, "w16_dn2");
        step(16, D,      1'b1, 16'h0000, 16'h0, 16'h0000, 1'b1, 1'b0, "w16_d0");
        step(16, CNT_DN, 1'b1, 16'h0,    16'h0, 16'hFFFF, 1'b1, 1'b0, "w16_wrap");
        step(16, CNT_UP, 1'b1, 16'h0,    16'h0, 16'h0000, 1'b1, 1'b0, "w16_upwrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
